// File: rtl/inst_mem_resp.sv
// Instruction-fetch responder: word-addressed instruction store with programmable
// wait states, ready/valid handshake, branch flush and a program-load side port.
module inst_mem_resp #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       pc_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic              err_o,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i
);

  // state | meaning
  // IDLE  | no fetch in flight, ready for a request
  // WAIT  | fetch accepted, counting wait states, not ready
  // RESP  | response presented this cycle, ready for the next request
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [31:0]       cap_pc, cap_pc_nxt;
  logic              resp_load;
  logic [31:0]       rd_pc;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_err;

  logic [31:0] store [0:(1<<ADDR_W)-1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cap_pc_nxt = cap_pc;
    resp_load  = 1'b0;
    rd_pc      = cap_pc;
    ready_o    = 1'b0;
    case (state)
      IDLE, RESP: begin
        ready_o = 1'b1;
        if (ce_i) begin
          cap_pc_nxt = pc_i;
          if (WAIT_STATES == 0) begin
            // Zero wait states: the store is read on the accept edge itself.
            state_nxt = RESP;
            resp_load = 1'b1;
            rd_pc     = pc_i;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS4;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_nxt = RESP;
          resp_load = 1'b1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_idx = rd_pc[ADDR_W+1:2];
  assign rd_err = (rd_pc[1:0] != 2'b00) || (rd_pc[31:ADDR_W+2] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      cap_pc <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cap_pc <= cap_pc_nxt;
    end
  end

  // Load writes are independent of reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (ld_we_i) store[ld_addr_i] <= ld_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o <= NOP_INST;
      pc_o   <= 32'd0;
      err_o  <= 1'b0;
    end else if (resp_load) begin
      inst_o <= rd_err ? NOP_INST : store[rd_idx];
      pc_o   <= rd_pc;
      err_o  <= rd_err;
    end
  end

  assign inst_valid_o = (state == RESP);

endmodule
